multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle sequencer for the RISC-V datapath: FSM stepping each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Drives mux selects, write enables and a shared instruction/data memory request with a ready handshake.
//  Supports R-type (0110011), ld (0000011), sd (0100011), beq (1100011). Sits between IR/memory and the datapath.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles mem_req may wait for mem_ready before abort (>=2); counter width $clog2(MEM_TIMEOUT)+1
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  opcode      in   7  IR[6:0], valid from DECODE onward
//  mem_ready   in   1  memory completes access this cycle
//  mem_req     out  1  memory access request
//  mem_we      out  1  write (sd) when mem_req=1
//  i_or_d      out  1  address select: 0=PC, 1=ALUOut
//  ir_write    out  1  load IR
//  pc_write    out  1  unconditional PC load (PC+4)
//  branch      out  1  conditional PC load; datapath ANDs with zero
//  alu_src_a   out  2  00=PC, 01=rs1
//  alu_src_b   out  2  00=rs2, 01=const 4, 10=imm
//  alu_op      out  2  00=add, 01=sub(beq), 10=funct-decoded
//  reg_write   out  1  register file write
//  mem_to_reg  out  1  WB source: 1=MDR, 0=ALUOut
//  bus_err     out  1  one-cycle pulse on memory timeout
//  trap        out  1  illegal opcode halt (ILLEGAL_TRAP_EN only)
//  state_o     out  3  current state, debug
// BEHAVIOUR
//  - States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6. State, op_q, wait counter, bus_err registered.
//  - Reset (async): state=IDLE, op_q=0, cnt=0, bus_err=0; all outputs 0. IDLE->FETCH next edge unconditionally.
//  - Outputs are Moore decode of state (+op_q); unlisted outputs 0 in each state.
//  - FETCH: mem_req=1, i_or_d=0, a=00, b=01, op=00; ir_write=pc_write=mem_ready. mem_ready=1 -> DECODE.
//  - DECODE: op_q<=opcode; a=00, b=10, op=00 (branch target). Legal -> EXEC; illegal -> see CONFIGURATION.
//  - EXEC: R a=01 b=00 op=10 -> WB; ld/sd a=01 b=10 op=00 -> MEM; beq a=01 b=00 op=01 branch=1 -> FETCH.
//  - MEM: mem_req=1, i_or_d=1, mem_we=(op_q==sd). mem_ready=1: ld->WB, sd->FETCH.
//  - WB: reg_write=1, mem_to_reg=(op_q==ld) -> FETCH.
//  - Zero-wait latency: beq 3, R/sd 4, ld 5 cycles FETCH-to-FETCH; each wait cycle adds 1.
//  - Wait counter: cleared on entering FETCH/MEM; +1 per cycle mem_req=1 && !mem_ready. At cnt==MEM_TIMEOUT-1 with
//    !mem_ready: next state IDLE, bus_err=1 for exactly one cycle, no reg_write/pc_write issued for the aborted instr.
//  - mem_ready ignored outside FETCH/MEM. mem_ready on the timeout cycle wins (normal advance, no bus_err).
//  - Reset mid-instruction: immediate IDLE, no further writes; instruction lost.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP; trap=1, all other outputs 0, held until reset.
//  Not defined: illegal opcode treated as NOP, DECODE->FETCH; trap tied 0, state 6 unreachable.
// TESTING
//  1 reset, mem_ready=1, opcode=0110011 -> states 0,1,2,3,5,1; reg_write=1 only in WB, mem_to_reg=0.
//  2 opcode=0000011, mem_ready=1 -> 1,2,3,4,5; MEM: mem_req=1 i_or_d=1 mem_we=0; WB mem_to_reg=1.
//  3 opcode=0100011, mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_we=1 throughout, then FETCH.
//  4 opcode=1100011 -> EXEC branch=1 alu_op=01, FETCH after 3 cycles; pc_write only on FETCH ready cycle.
//  5 mem_ready=0 forever in FETCH, MEM_TIMEOUT=16 -> after 16 FETCH cycles state IDLE, bus_err 1 cycle, retry FETCH.
//  6 opcode=1111111 -> with ILLEGAL_TRAP_EN: state 6, trap=1 until reset; without: DECODE->FETCH, trap=0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle sequencer for a RISC-V datapath. Each instruction is stepped
//   through FETCH/DECODE/EXEC/MEM/WB. The controller drives mux selects and
//   write enables. It also drives a shared instruction/data memory request
//   with a ready handshake.
//   Supported opcodes: R-type 0110011, ld 0000011, sd 0100011, beq 1100011.
//
//   Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an illegal
//   opcode halts in TRAP until reset. Otherwise an illegal opcode is treated
//   as a NOP.
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   opcode[6:0]         IR[6:0], valid from DECODE onward
//   mem_ready           memory completes access this cycle
//   mem_req, mem_we     memory request / write (sd)
//   i_or_d              address select 0=PC, 1=ALUOut
//   ir_write, pc_write  IR load, unconditional PC load
//   branch              conditional PC load (datapath ANDs with zero)
//   alu_src_a[1:0]      00=PC, 01=rs1
//   alu_src_b[1:0]      00=rs2, 01=4, 10=imm
//   alu_op[1:0]         00=add, 01=sub, 10=funct-decoded
//   reg_write           register file write
//   mem_to_reg          WB source 1=MDR, 0=ALUOut
//   bus_err             one-cycle pulse after a memory timeout
//   trap                illegal-opcode halt
//   state_o[2:0]        current state (debug)
//
// state  | meaning
// IDLE   | after reset or timeout abort; always proceeds to FETCH
// FETCH  | instruction read at PC, IR/PC loaded on mem_ready
// DECODE | latch opcode, compute branch target
// EXEC   | ALU operation / address calc / branch compare
// MEM    | data read (ld) or write (sd)
// WB     | register file write-back
// TRAP   | illegal opcode halt (only with ILLEGAL_TRAP_EN)
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       bus_err,
  output logic       trap,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t        state;
  logic [6:0]    op_q;
  logic [CW-1:0] cnt;
  logic          bus_err_q;
  logic          legal;
  logic          timeout;

  assign legal = (opcode == OP_R) || (opcode == OP_LD) ||
                 (opcode == OP_SD) || (opcode == OP_BEQ);

  // A ready on the last allowed cycle still completes normally.
  assign timeout = (cnt == CW'(MEM_TIMEOUT - 1)) && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        IDLE: begin
          state <= FETCH;
          cnt   <= '0;
        end
        FETCH: begin
          if (mem_ready) begin
            state <= DECODE;
          end else if (timeout) begin
            state     <= IDLE;
            bus_err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DECODE: begin
          op_q <= opcode;
          if (legal) begin
            state <= EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state <= TRAP;
`else
            state <= FETCH;
            cnt   <= '0;
`endif
          end
        end
        EXEC: begin
          if (op_q == OP_R) begin
            state <= WB;
          end else if (op_q == OP_LD || op_q == OP_SD) begin
            state <= MEM;
            cnt   <= '0;
          end else begin
            state <= FETCH;
            cnt   <= '0;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (op_q == OP_LD) begin
              state <= WB;
            end else begin
              state <= FETCH;
              cnt   <= '0;
            end
          end else if (timeout) begin
            state     <= IDLE;
            bus_err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WB: begin
          state <= FETCH;
          cnt   <= '0;
        end
        TRAP: state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = 2'b10;
      EXEC: begin
        alu_src_a = 2'b01;
        if (op_q == OP_R) begin
          alu_op = 2'b10;
        end else if (op_q == OP_LD || op_q == OP_SD) begin
          alu_src_b = 2'b10;
        end else begin
          alu_op = 2'b01;
          branch = 1'b1;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = (op_q == OP_SD);
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LD);
      end
      default: ;
    endcase
  end

  assign bus_err = bus_err_q;
  assign state_o = state;
`ifdef ILLEGAL_TRAP_EN
  assign trap = (state == TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, branch;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, bus_err, trap;
  logic [2:0] state_o;

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .bus_err(bus_err), .trap(trap), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [18:0] exp_q[$];

  // instruction classes: 0=R 1=ld 2=sd 3=beq 4=illegal
  function automatic logic [6:0] cls_opcode(int cls);
    logic [6:0] o;
    case (cls)
      0: o = 7'b0110011;
      1: o = 7'b0000011;
      2: o = 7'b0100011;
      3: o = 7'b1100011;
      default: begin
        o = 7'($urandom);
        for (int k = 0; k < 32; k++)
          if (o == 7'b0110011 || o == 7'b0000011 || o == 7'b0100011 || o == 7'b1100011)
            o = 7'($urandom);
        if (o == 7'b0110011 || o == 7'b0000011 || o == 7'b0100011 || o == 7'b1100011)
          o = 7'b1111111;
      end
    endcase
    return o;
  endfunction

  // Expected output bundle for one cycle, straight from the per-state table:
  // {state, req, we, iod, irw, pcw, br, a, b, op, rw, m2r, be, tr}
  function automatic logic [18:0] exp_vec(int st, int cls, bit rdy, bit be);
    logic req, we, iod, irw, pcw, br, rw, m2r, tr;
    logic [1:0] a, b, op;
    logic [2:0] s;
    s = 3'(st);
    {req, we, iod, irw, pcw, br, rw, m2r, tr} = '0;
    a = 2'b00; b = 2'b00; op = 2'b00;
    case (st)
      1: begin req = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      2: b = 2'b10;
      3: begin
        a = 2'b01;
        if (cls == 0) op = 2'b10;
        else if (cls == 1 || cls == 2) b = 2'b10;
        else begin op = 2'b01; br = 1; end
      end
      4: begin req = 1; iod = 1; we = (cls == 2); end
      5: begin rw = 1; m2r = (cls == 1); end
      6: tr = 1;
      default: ;
    endcase
    return {s, req, we, iod, irw, pcw, br, a, b, op, rw, m2r, be, tr};
  endfunction

  task automatic step(input logic [6:0] opc, input bit rdy, input logic [18:0] e);
    @(posedge clk);
    #1;
    opcode    = opc;
    mem_ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.push_back(exp_vec(0, 0, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(exp_vec(0, 0, 0, 0));
  endtask

  // A memory access that completes after wt wait cycles, or aborts if wt
  // reaches the timeout budget (IDLE with bus_err follows).
  task automatic mem_phase(input int st, input int cls, input int wt, output bit ok);
    bit rdy;
    bit done;
    ok = 0;
    done = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      if (!done) begin
        rdy = (i == wt);
        step(7'($urandom), rdy, exp_vec(st, cls, rdy, 0));
        if (rdy) begin ok = 1; done = 1; end
      end
    end
    if (!ok) step(7'($urandom), 1'($urandom), exp_vec(0, cls, 0, 1));
  endtask

  task automatic run_instr(input int cls, input int wf, input int wm);
    bit ok;
    logic [6:0] opc;
    opc = cls_opcode(cls);
    mem_phase(1, cls, wf, ok);
    if (ok) begin
      step(opc, 1'($urandom), exp_vec(2, cls, 0, 0));
      case (cls)
        0: begin
          step(7'($urandom), 1'($urandom), exp_vec(3, cls, 0, 0));
          step(7'($urandom), 1'($urandom), exp_vec(5, cls, 0, 0));
        end
        1: begin
          step(7'($urandom), 1'($urandom), exp_vec(3, cls, 0, 0));
          mem_phase(4, cls, wm, ok);
          if (ok) step(7'($urandom), 1'($urandom), exp_vec(5, cls, 0, 0));
        end
        2: begin
          step(7'($urandom), 1'($urandom), exp_vec(3, cls, 0, 0));
          mem_phase(4, cls, wm, ok);
        end
        3: step(7'($urandom), 1'($urandom), exp_vec(3, cls, 0, 0));
        default: begin
`ifdef ILLEGAL_TRAP_EN
          for (int k = 0; k < 4; k++)
            step(7'($urandom), 1'($urandom), exp_vec(6, cls, 0, 0));
          do_reset();
`endif
        end
      endcase
    end
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 16 + int'($urandom_range(0, 4));
    if (r == 1) return 15;
    return int'($urandom_range(0, 3));
  endfunction

  // Monitor: every cycle is an output presentation of this Moore controller.
  initial begin
    logic [18:0] act, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {state_o, mem_req, mem_we, i_or_d, ir_write, pc_write, branch,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, bus_err, trap};
        tests++;
        if (act !== e) begin
          fails++;
          $display("FAIL cycle_outputs t=%0t state=%0d: got %b required %b", $time, e[18:16], act, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset     = 1'b1;
    opcode    = 7'd0;
    mem_ready = 1'b0;
    do_reset();

    run_instr(0, 0, 0);
    run_instr(1, 0, 0);
    run_instr(2, 0, 3);
    run_instr(3, 0, 0);
    run_instr(0, 20, 0);
    run_instr(1, 1, 20);
    run_instr(2, 15, 15);
    run_instr(4, 0, 0);
    run_instr(3, 2, 0);

    mem_phase(1, 0, 0, ok);
    step(7'b0110011, 1'b1, exp_vec(2, 0, 0, 0));
    do_reset();
    run_instr(1, 0, 1);

    for (int n = 0; n < 80; n++)
      run_instr(int'($urandom_range(0, 4)), rand_wait(), rand_wait());

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
